// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that shares one single-port word RAM among CHANNELS clients.
// Each granted access takes LATENCY cycles, then pulses ready to its client for one cycle.
module mem_port_arbiter #(
    parameter int CHANNELS   = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 4,
    localparam int ID_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [CHANNELS-1:0]            req,
    input  logic [CHANNELS-1:0]            we,
    input  logic [CHANNELS*ADDR_WIDTH-1:0] addr,
    input  logic [CHANNELS*DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic [CHANNELS-1:0]            ready,
    output logic [ID_W-1:0]                grant_id,
    output logic                           busy
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ID_W-1:0]         last_q, last_d;
    logic [ID_W-1:0]         grant_q, grant_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    mem_we;

    logic [DATA_WIDTH-1:0]   mem [2**DEPTH_LOG2];

    logic [ADDR_WIDTH-1:0]   addr_a  [CHANNELS];
    logic [DATA_WIDTH-1:0]   wdata_a [CHANNELS];
    logic [ID_W-1:0]         cand;
    logic [ID_W-1:0]         sel;
    logic                    found;
    logic [DEPTH_LOG2-1:0]   idx;
    logic                    unused_addr_q;

    assign idx           = addr_q[DEPTH_LOG2+1:2];
    assign unused_addr_q = ^addr_q;

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            addr_a[i]  = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_a[i] = wdata[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Round-robin search starts just past the last served client and wraps.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int i = 1; i <= CHANNELS; i++) begin
            cand = ID_W'((int'(last_q) + i) % CHANNELS);
            if (!found && req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        grant_d = grant_q;
        rdata_d = rdata_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = sel;
                    we_d    = we[sel];
                    addr_d  = addr_a[sel];
                    wdata_d = wdata_a[sel];
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    if (we_q) mem_we = 1'b1;
                    else      rdata_d = mem[idx];
                    state_d = DONE;
                end
            end
            DONE: begin
                last_d  = grant_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= ID_W'(CHANNELS - 1);
            grant_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            rdata_q <= rdata_d;
        end
    end

    // Latched request fields and RAM contents are deliberately not reset.
    always_ff @(posedge clock) begin
        we_q    <= we_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        if (mem_we && !reset) mem[idx] <= wdata_q;
    end

    // Reset during DONE must also hide the pulse in that same cycle.
    assign ready    = (state_q == DONE && !reset) ? (CHANNELS'(1) << grant_q) : '0;
    assign rdata    = rdata_q;
    assign grant_id = grant_q;
    assign busy     = (state_q != IDLE);

endmodule
